muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit; sits directly downstream of the register file read ports.
- Consumes rdata1/rdata2 as operands and produces a write-back triple (result, destination register, write enable) that drives the register file write port (wdata/rd/wenb).
- Performs one shift-add or restoring-subtract step per cycle, plus a final sign-fix cycle.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the iteration counter is 5 bits.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- flush  input  1  abort in-flight op; no done is produced
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- op_a  input  32  rs1 operand, from rdata1
- op_b  input  32  rs2 operand, from rdata2
- rd_in  input  5  destination register index
- busy  output  1  high in CALC and FIN
- done  output  1  one-cycle pulse; result valid
- result  output  32  write-back data, to wdata
- rd_out  output  5  latched rd_in, to rd
- wenb_out  output  1  equals done, to wenb

Behaviour:
- Reset (synchronous, active-high) forces:
  - state IDLE
  - busy, done, wenb_out = 0
  - result = 0, rd_out = 0
  - all internal registers cleared
- Reset mid-operation aborts the op; no done is produced.
- States: IDLE, CALC, FIN.
- IDLE:
  - start=1 at edge E0 latches funct3, op_a, op_b, rd_in.
  - Operands are converted to magnitudes per signedness:
    - MULH: both signed.
    - MULHSU: op_a signed, op_b unsigned.
    - DIV/REM: both signed.
  - Result sign is recorded; count is set to 0; state goes to CALC.
- CALC: one step per cycle; count increments each cycle.
  - Multiply: 64-bit shift-add accumulator.
  - Divide: restoring division producing a 32-bit quotient and a 32-bit remainder.
  - After the step at count=31 (edge E32), state goes to FIN.
- FIN:
  - Apply sign correction:
    - Product: negate the 64-bit value if the result sign is negative.
    - Quotient: negate if operand signs differ.
    - Remainder: takes the dividend's sign.
  - Select the output word:
    - MUL: low 32 bits of the product.
    - MULH/MULHSU/MULHU: high 32 bits of the product.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - At edge E33: result and rd_out are registered, done = wenb_out = 1 for exactly one cycle, state returns to IDLE.
- Latency: done is high in the cycle following E33, i.e. 33 clocks after the accepting edge.
- result and rd_out hold their value after done until the next completion.
- Divide by zero (op_b = 0):
  - DIV/DIVU give 0xFFFFFFFF.
  - REM/REMU give op_a.
  - Handled in FIN; latency is unchanged.
- Signed overflow (DIV/REM with op_a = 0x80000000, op_b = 0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- start while busy is ignored, with no queuing.
- start in the done cycle is accepted, because the state is already IDLE.
- flush in CALC or FIN: next state IDLE, no done, result and rd_out unchanged.
- flush and start together in IDLE: flush wins and start is dropped.
- rd_in = 0 still produces done/wenb_out; the register file discards the write.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - At acceptance, divide-by-zero and signed-overflow cases go IDLE -> FIN directly, skipping CALC.
  - done is high in the cycle after E1, i.e. 1 clock after acceptance.
  - All other ops keep 33-cycle latency.
- Undefined: every op takes 33 cycles; special cases are resolved in FIN only.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3), rd_in=5 -> done pulse 33 clocks after the accepting edge, result=0xFFFFFFEB, rd_out=5, wenb_out=1 for one cycle.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. Latency is 33 without MULDIV_EARLY_OUT_EN and 1 with it.
- start pulsed at cycle 10 of CALC is ignored (single done). flush at cycle 20 -> no done, busy=0 the next cycle. A new start in the done cycle is accepted.
- reset asserted mid-CALC -> next cycle busy=0, done=0, result=0, rd_out=0. No done appears afterwards without a new start.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Handshake and operand bus between the register-file read/write ports and muldiv_unit.
// Master drives the request side; slave (the unit) drives the write-back side.
// The write-back triple is result/rd_out/wenb_out.
interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic            flush;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [4:0]      rd_in;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;
   logic            wenb_out;

   modport master (
      output start, flush, funct3, op_a, op_b, rd_in,
      input  busy, done, result, rd_out, wenb_out
   );

   modport slave (
      input  start, flush, funct3, op_a, op_b, rd_in,
      output busy, done, result, rd_out, wenb_out
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add / restoring-subtract step per cycle.
// Latency 33 clocks from the accepting edge to done; 1 clock for div-by-zero/overflow when
// MULDIV_EARLY_OUT_EN is defined. start is ignored while busy (no queuing); flush aborts.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic          clk,
   input  logic          reset,
   muldiv_unit_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state, state_nxt;
   logic [4:0]        count;
   logic [2:0]        f3_q;
   logic [XLEN-1:0]   acc_hi, acc_lo, mcand, a_raw;
   logic              sign_a, sign_b, b_zero, ovf;
   logic [4:0]        rd_q;
   logic              done_q;
   logic [XLEN-1:0]   result_q;
   logic [4:0]        rd_out_q;

   logic              accept;
   logic              a_sgn_in, b_sgn_in, b_zero_in, ovf_in;
   logic [XLEN-1:0]   a_mag_in, b_mag_in;
   logic [XLEN:0]     mul_sum;
   logic [XLEN-1:0]   mul_hi, mul_lo;
   logic [XLEN:0]     div_trial;
   logic              div_ge;
   logic [XLEN-1:0]   div_diff, div_hi, div_lo;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fin_word;

   // Request decode: magnitudes and special-case flags from the raw operands
   always_comb begin
      accept    = (state == IDLE) && bus.start && !bus.flush;
      a_sgn_in  = bus.op_a[XLEN-1] && ((bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
                                       (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6));
      b_sgn_in  = bus.op_b[XLEN-1] && ((bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) ||
                                       (bus.funct3 == 3'd6));
      a_mag_in  = a_sgn_in ? -bus.op_a : bus.op_a;
      b_mag_in  = b_sgn_in ? -bus.op_b : bus.op_b;
      b_zero_in = (bus.op_b == '0);
      ovf_in    = ((bus.funct3 == 3'd4) || (bus.funct3 == 3'd6)) &&
                  (bus.op_a == MIN_NEG) && (bus.op_b == '1);
   end

   // One iteration step: acc_hi:acc_lo is the product accumulator or remainder:quotient pair
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
      mul_hi    = mul_sum[XLEN:1];
      mul_lo    = {mul_sum[0], acc_lo[XLEN-1:1]};
      div_trial = {acc_hi, acc_lo[XLEN-1]};
      div_ge    = (div_trial >= {1'b0, mcand});
      div_diff  = div_trial[XLEN-1:0] - mcand;
      div_hi    = div_ge ? div_diff : div_trial[XLEN-1:0];
      div_lo    = {acc_lo[XLEN-2:0], div_ge};
   end

   // Sign fix-up and word select for the FIN cycle; div special cases override the datapath
   always_comb begin
      prod     = {acc_hi, acc_lo};
      prod_fix = (sign_a ^ sign_b) ? -prod : prod;
      quo_fix  = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
      rem_fix  = sign_a ? -acc_hi : acc_hi;
      fin_word = '0;
      case (f3_q)
         3'd0:                fin_word = prod_fix[XLEN-1:0];
         3'd1, 3'd2, 3'd3:    fin_word = prod_fix[2*XLEN-1:XLEN];
         3'd4, 3'd5:          fin_word = b_zero ? '1 : (ovf ? MIN_NEG : quo_fix);
         default:             fin_word = b_zero ? a_raw : (ovf ? '0 : rem_fix);
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; flush returns to IDLE from any busy state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef MULDIV_EARLY_OUT_EN
               state_nxt = (bus.funct3[2] && (b_zero_in || ovf_in)) ? FIN : CALC;
`else
               state_nxt = CALC;
`endif
            end
         end
         CALC:    state_nxt = bus.flush ? IDLE : ((count == 5'd31) ? FIN : CALC);
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture at acceptance and one iteration per CALC cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= '0;
         f3_q   <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         mcand  <= '0;
         a_raw  <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         b_zero <= 1'b0;
         ovf    <= 1'b0;
         rd_q   <= '0;
      end else if (accept) begin
         count  <= '0;
         f3_q   <= bus.funct3;
         a_raw  <= bus.op_a;
         sign_a <= a_sgn_in;
         sign_b <= b_sgn_in;
         b_zero <= b_zero_in;
         ovf    <= ovf_in;
         rd_q   <= bus.rd_in;
         acc_hi <= '0;
         acc_lo <= bus.funct3[2] ? a_mag_in : b_mag_in;
         mcand  <= bus.funct3[2] ? b_mag_in : a_mag_in;
      end else if ((state == CALC) && !bus.flush) begin
         count  <= count + 5'd1;
         acc_hi <= f3_q[2] ? div_hi : mul_hi;
         acc_lo <= f3_q[2] ? div_lo : mul_lo;
      end
   end

   // Write-back registers: updated only on an unflushed FIN, held otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         done_q   <= 1'b0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         done_q <= (state == FIN) && !bus.flush;
         if ((state == FIN) && !bus.flush) begin
            result_q <= fin_word;
            rd_out_q <= rd_q;
         end
      end
   end

   // Outputs
   always_comb begin
      bus.busy     = (state != IDLE);
      bus.done     = done_q;
      bus.wenb_out = done_q;
      bus.result   = result_q;
      bus.rd_out   = rd_out_q;
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, control corner cases, random ops.
// Expected results come from 64-bit arithmetic on the RV32M definitions.
// Every wait on done is bounded.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] last_result;

   always #5 clk = ~clk;

   muldiv_unit_if bus ();
   muldiv_unit dut (.clk(clk), .reset(reset), .bus(bus));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      return f3[2] && ((b == 32'h0) ||
                       (((f3 == 3'd4) || (f3 == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
   endfunction

   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      t  = 64'h0;
      case (f3)
         3'd0: begin t = sa * sb; return t[31:0];  end
         3'd1: begin t = sa * sb; return t[63:32]; end
         3'd2: begin t = sa * ub; return t[63:32]; end
         3'd3: begin t = ua * ub; return t[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            t = sa / sb; return t[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            t = ua / ub; return t[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            t = sa % sb; return t[31:0];
         end
         default: begin
            if (b == 0) return a;
            t = ua % ub; return t[31:0];
         end
      endcase
   endfunction

   // Issues one op from the current (off-edge) time and checks the write-back
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit chk_pulse);
      int n;
      int lat;
      logic [31:0] exp;
      exp = ref_model(f3, a, b);
`ifdef MULDIV_EARLY_OUT_EN
      lat = is_special(f3, a, b) ? 1 : 33;
`else
      lat = 33;
`endif
      bus.funct3 = f3;
      bus.op_a   = a;
      bus.op_b   = b;
      bus.rd_in  = rd;
      bus.start  = 1'b1;
      tick();
      bus.start  = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.done && n < 100);
      chk($sformatf("latency f3=%0d", f3), n, lat);
      chk($sformatf("result f3=%0d a=%h b=%h", f3, a, b), bus.result, exp);
      chk("rd_out", {27'h0, bus.rd_out}, {27'h0, rd});
      chk("wenb_out", {31'h0, bus.wenb_out}, 32'h1);
      last_result = exp;
      if (chk_pulse) begin
         tick();
         chk("done_one_cycle", {31'h0, bus.done}, 32'h0);
         chk("result_hold", bus.result, exp);
      end
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      int d;
      d = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (bus.done) d++;
      end
      chk(tag, d, 0);
   endtask

   logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

   initial begin
      int n, dones, first_n;
      logic [31:0] exp, first_res, ra, rb;
      bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'd0;
      bus.op_a = 32'h0; bus.op_b = 32'h0; bus.rd_in = 5'd0;
      last_result = 32'h0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      chk("reset busy",   {31'h0, bus.busy},     32'h0);
      chk("reset done",   {31'h0, bus.done},     32'h0);
      chk("reset wenb",   {31'h0, bus.wenb_out}, 32'h0);
      chk("reset result", bus.result,            32'h0);
      chk("reset rd_out", {27'h0, bus.rd_out},   32'h0);

      // Directed arithmetic cases
      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b1);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1);
      run_op(3'd5, 32'd100, 32'd7, 5'd7, 1'b1);
      run_op(3'd7, 32'd100, 32'd7, 5'd8, 1'b1);
      run_op(3'd5, 32'd5, 32'd0, 5'd9, 1'b1);
      run_op(3'd7, 32'd5, 32'd0, 5'd10, 1'b1);
      run_op(3'd4, 32'hFFFF_FFF0, 32'd0, 5'd11, 1'b1);
      run_op(3'd6, 32'hFFFF_FFF0, 32'd0, 5'd12, 1'b1);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1);
      run_op(3'd0, 32'd3, 32'd4, 5'd0, 1'b1);

      // start in the done cycle is accepted: second op begins right at the done sample
      run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15, 1'b0);
      run_op(3'd5, 32'hDEAD_BEEF, 32'd3, 5'd16, 1'b1);

      // start pulsed at cycle 10 of CALC is ignored
      exp = ref_model(3'd1, 32'hF000_0001, 32'h0000_0123);
      bus.funct3 = 3'd1; bus.op_a = 32'hF000_0001; bus.op_b = 32'h0000_0123; bus.rd_in = 5'd17;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      n = 0; dones = 0; first_n = 0; first_res = 32'h0;
      for (int i = 0; i < 10; i++) begin tick(); n++; end
      bus.funct3 = 3'd0; bus.op_a = 32'd1; bus.op_b = 32'd1; bus.rd_in = 5'd1;
      bus.start = 1'b1; tick(); n++; bus.start = 1'b0;
      while (n < 80) begin
         tick(); n++;
         if (bus.done) begin
            dones++;
            if (dones == 1) begin first_n = n; first_res = bus.result; end
         end
      end
      chk("ignored start dones", dones, 1);
      chk("ignored start latency", first_n, 33);
      chk("ignored start result", first_res, exp);
      last_result = exp;

      // flush at cycle 20 of CALC: no done, busy drops, result held
      bus.funct3 = 3'd5; bus.op_a = 32'd1000; bus.op_b = 32'd9; bus.rd_in = 5'd18;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      for (int i = 0; i < 19; i++) tick();
      bus.flush = 1'b1; tick(); bus.flush = 1'b0;
      chk("flush busy", {31'h0, bus.busy}, 32'h0);
      expect_quiet("flush no done", 40);
      chk("flush result held", bus.result, last_result);

      // flush and start together in IDLE: start dropped
      bus.flush = 1'b1; bus.start = 1'b1; tick(); bus.flush = 1'b0; bus.start = 1'b0;
      chk("flush+start busy", {31'h0, bus.busy}, 32'h0);
      expect_quiet("flush+start no done", 40);

      // reset mid-CALC
      bus.funct3 = 3'd0; bus.op_a = 32'd11; bus.op_b = 32'd13; bus.rd_in = 5'd19;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      chk("midreset busy",   {31'h0, bus.busy},   32'h0);
      chk("midreset done",   {31'h0, bus.done},   32'h0);
      chk("midreset result", bus.result,          32'h0);
      chk("midreset rd_out", {27'h0, bus.rd_out}, 32'h0);
      expect_quiet("midreset no done", 40);

      // Random ops, biased toward boundary operands
      for (int k = 0; k < 40; k++) begin
         ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
         run_op(3'($urandom_range(0, 7)), ra, rb, 5'($urandom_range(0, 31)), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
